// File: rtl/matrix_operand_loader.sv
// ----------------------------------------------------------------------------
// matrix_operand_loader
//   Upstream operand stage of the matrix multiplier. Words arriving over a
//   valid/ready handshake fill a ROWS-deep operand buffer while the controller
//   holds load_en. Once the buffer is full, load_done is raised. Each
//   shift_data_en pulse then rotates the buffer one word toward the ALU. The
//   buffer is released back to IDLE after ROWS shifts.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   load_en        controller: filling allowed (level)
//   shift_data_en  controller: rotate buffer one word (per cycle, FULL only)
//   flush          synchronous clear of buffer, counters and FSM
//   wr_valid       bus word present on wr_data
//   wr_data        bus word
//   wr_ready       loader accepts wr_data this cycle (combinational)
//   load_done      buffer full, operands valid (registered state decode)
//   operand_bus    buf[0] in bits [DATA_W-1:0], buf[i] in the next slice up
//   head_word      buf[0], the word presented to the ALU
//   fill_cnt       words accepted in the current load (saturates at ROWS)
//   shift_cnt      shifts performed on the current load (saturates at ROWS)
// ----------------------------------------------------------------------------
module matrix_operand_loader #(
  parameter int DATA_W = 8,
  parameter int ROWS   = 4,
  parameter int CNT_W  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic                   shift_data_en,
  input  logic                   flush,
  input  logic                   wr_valid,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   wr_ready,
  output logic                   load_done,
  output logic [ROWS*DATA_W-1:0] operand_bus,
  output logic [DATA_W-1:0]      head_word,
  output logic [CNT_W-1:0]       fill_cnt,
  output logic [CNT_W-1:0]       shift_cnt
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [DATA_W-1:0] words [ROWS];
  logic              accept;
  logic              last_accept;
  logic              do_shift;
  logic              last_shift;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and handshake decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    wr_ready    = 1'b0;
    accept      = 1'b0;
    last_accept = 1'b0;
    do_shift    = 1'b0;
    last_shift  = 1'b0;

    if (flush) begin
      // Flush wins over everything. wr_ready is held low so the source does
      // not treat its word as consumed.
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_en) begin
            state_next = FILL;
          end
        end
        FILL: begin
          wr_ready    = load_en;
          accept      = wr_valid & load_en;
          last_accept = accept & (fill_cnt == LAST_IDX);
          if (last_accept) begin
            state_next = FULL;
          end
        end
        FULL: begin
          do_shift   = shift_data_en;
          last_shift = shift_data_en & (shift_cnt == LAST_IDX);
          if (last_shift) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Buffer and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ROWS; i++) begin
        words[i] <= '0;
      end
      fill_cnt  <= '0;
      shift_cnt <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < ROWS; i++) begin
        words[i] <= '0;
      end
      fill_cnt  <= '0;
      shift_cnt <= '0;
    end else begin
      if (state == IDLE && load_en) begin
        fill_cnt  <= '0;
        shift_cnt <= '0;
      end

      if (accept) begin
        // Slot select by compare avoids indexing with the wider counter.
        for (int unsigned i = 0; i < ROWS; i++) begin
          if (fill_cnt == CNT_W'(i)) begin
            words[i] <= wr_data;
          end
        end
        fill_cnt <= fill_cnt + ONE;
      end

      if (do_shift) begin
        for (int unsigned i = 0; i < ROWS - 1; i++) begin
          words[i] <= words[i+1];
        end
        words[ROWS-1] <= words[0];
        shift_cnt     <= shift_cnt + ONE;
        if (last_shift) begin
          fill_cnt <= '0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output decode (all from registers)
  // --------------------------------------------------------------------------
  assign load_done = (state == FULL);
  assign head_word = words[0];

  always_comb begin
    operand_bus = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      operand_bus[i*DATA_W +: DATA_W] = words[i];
    end
  end

endmodule
